// File: rtl/point_mult_sequencer.sv
// Sequential MSB-first double-and-add scalar-point multiplier controller.
// Shares one external combinational point adder over 2*WIDTH cycles; latency does not depend on n.
`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif

module point_mult_sequencer #(
    parameter int unsigned WIDTH = `DATAWIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] Qx,
    input  logic [WIDTH-1:0] Qy,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Rx_out,
    output logic [WIDTH-1:0] Ry_out,
    output logic [WIDTH-1:0] add_Px,
    output logic [WIDTH-1:0] add_Py,
    output logic [WIDTH-1:0] add_Qx,
    output logic [WIDTH-1:0] add_Qy,
    input  logic [WIDTH-1:0] add_Rx,
    input  logic [WIDTH-1:0] add_Ry
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] IdxTop = IdxW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StDouble, StAdd, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] qx_q, qx_d, qy_q, qy_d;
    logic [WIDTH-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [WIDTH-1:0] t_x_q, t_x_d, t_y_q, t_y_d;
    logic [WIDTH-1:0] rx_q, rx_d, ry_q, ry_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] sel_x, sel_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            n_q     <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            acc_x_q <= '0;
            acc_y_q <= '0;
            t_x_q   <= '0;
            t_y_q   <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            t_x_q   <= t_x_d;
            t_y_q   <= t_y_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        qx_d    = qx_q;
        qy_d    = qy_q;
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        t_x_d   = t_x_q;
        t_y_d   = t_y_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        idx_d   = idx_q;
        busy    = 1'b0;
        done    = 1'b0;
        add_Px  = '0;
        add_Py  = '0;
        add_Qx  = '0;
        add_Qy  = '0;
        // The add result is always computed; the bit only picks which value is kept.
        sel_x   = n_q[idx_q] ? add_Rx : t_x_q;
        sel_y   = n_q[idx_q] ? add_Ry : t_y_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    n_d     = n;
                    qx_d    = Qx;
                    qy_d    = Qy;
                    acc_x_d = '0;
                    acc_y_d = '0;
                    idx_d   = IdxTop;
                    state_d = StDouble;
                end
            end
            StDouble: begin
                busy    = 1'b1;
                add_Px  = acc_x_q;
                add_Py  = acc_y_q;
                add_Qx  = acc_x_q;
                add_Qy  = acc_y_q;
                t_x_d   = add_Rx;
                t_y_d   = add_Ry;
                state_d = StAdd;
            end
            StAdd: begin
                busy    = 1'b1;
                add_Px  = t_x_q;
                add_Py  = t_y_q;
                add_Qx  = qx_q;
                add_Qy  = qy_q;
                acc_x_d = sel_x;
                acc_y_d = sel_y;
                if (idx_q == '0) begin
                    rx_d    = sel_x;
                    ry_d    = sel_y;
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q - IdxW'(1);
                    state_d = StDouble;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign Rx_out = rx_q;
    assign Ry_out = ry_q;

endmodule

// File: tb/tb_point_mult_sequencer.sv
// Bench for point_mult_sequencer at WIDTH=8 with an additive stub adder, so n*Q reduces to
// per-coordinate multiplication mod 256.
module tb_point_mult_sequencer;

    localparam int unsigned W = 8;
    localparam int LAT = 2 * W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] n = '0, Qx = '0, Qy = '0;
    logic         busy, done;
    logic [W-1:0] Rx_out, Ry_out;
    logic [W-1:0] add_Px, add_Py, add_Qx, add_Qy, add_Rx, add_Ry;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] obs_px [0:2*W];
    logic [W-1:0] obs_py [0:2*W];
    logic [W-1:0] obs_qx [0:2*W];
    logic [W-1:0] obs_qy [0:2*W];
    logic [W-1:0] obs_rx [0:2*W];
    logic [W-1:0] obs_ry [0:2*W];
    int           lat, busy_cnt;
    logic [W-1:0] got_rx, got_ry;
    logic [W-1:0] last_x, last_y;

    point_mult_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .n      (n),
        .Qx     (Qx),
        .Qy     (Qy),
        .busy   (busy),
        .done   (done),
        .Rx_out (Rx_out),
        .Ry_out (Ry_out),
        .add_Px (add_Px),
        .add_Py (add_Py),
        .add_Qx (add_Qx),
        .add_Qy (add_Qy),
        .add_Rx (add_Rx),
        .add_Ry (add_Ry)
    );

    assign add_Rx = add_Px + add_Qx;
    assign add_Ry = add_Py + add_Qy;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] smul(input int unsigned k, input int unsigned q);
        int unsigned p;
        p = (k * q) & 32'hFF;
        return p[W-1:0];
    endfunction

    // Runs one operation from an idle point, recording the operand buses every cycle.
    task automatic do_op(input logic [W-1:0] nv, input logic [W-1:0] qxv, input logic [W-1:0] qyv);
        int guard;
        guard = 0;
        @(negedge clk);
        while ((busy || done) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        start = 1'b1;
        n = nv;
        Qx = qxv;
        Qy = qyv;
        @(posedge clk);
        lat = 1;
        busy_cnt = 0;
        #1;
        start = 1'b0;
        n = W'($urandom);
        Qx = W'($urandom);
        Qy = W'($urandom);
        @(negedge clk);
        for (int g = 0; g < 64; g++) begin
            if (lat - 1 <= 2 * W) begin
                obs_px[lat-1] = add_Px;
                obs_py[lat-1] = add_Py;
                obs_qx[lat-1] = add_Qx;
                obs_qy[lat-1] = add_Qy;
                obs_rx[lat-1] = Rx_out;
                obs_ry[lat-1] = Ry_out;
            end
            if (busy) busy_cnt++;
            if (done) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!done) lat = -1;
        got_rx = Rx_out;
        got_ry = Ry_out;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, done, Rx_out, Ry_out} !== {2'b00, 16'h0}) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%0b done=%0b R=(%0h,%0h) required 0,0,(0,0)",
                     busy, done, Rx_out, Ry_out);
        end
        vectors++;
        if ({add_Px, add_Py, add_Qx, add_Qy} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_operands: got %0h %0h %0h %0h required all 0",
                     add_Px, add_Py, add_Qx, add_Qy);
        end
        rst = 1'b0;
    endtask

    task automatic test_stub_arith();
        do_op(8'hB5, 8'd3, 8'd7);
        vectors++;
        if ({got_rx, got_ry} !== 16'h1FF3) begin
            miscompares++;
            $display("FAIL stub_arith_result: got (%0h,%0h) required (1f,f3)", got_rx, got_ry);
        end
        vectors++;
        if (lat != LAT) begin
            miscompares++;
            $display("FAIL stub_arith_latency: got %0d required %0d", lat, LAT);
        end
        vectors++;
        if (busy_cnt != 2 * W) begin
            miscompares++;
            $display("FAIL stub_arith_busy: got %0d cycles required %0d", busy_cnt, 2 * W);
        end
    endtask

    task automatic test_scalar_extremes();
        logic [W-1:0] tn [3];
        logic [W-1:0] tqx [3];
        logic [W-1:0] tqy [3];
        logic [W-1:0] ex [3];
        logic [W-1:0] ey [3];
        tn = '{8'h00, 8'h01, 8'hFF};
        tqx = '{8'h5A, 8'd9, 8'd1};
        tqy = '{8'h3C, 8'd4, 8'd2};
        ex = '{8'h00, 8'd9, 8'hFF};
        ey = '{8'h00, 8'd4, 8'hFE};
        for (int i = 0; i < 3; i++) begin
            do_op(tn[i], tqx[i], tqy[i]);
            vectors++;
            if (got_rx !== ex[i] || got_ry !== ey[i]) begin
                miscompares++;
                $display("FAIL extremes_result n=%0h: got (%0h,%0h) required (%0h,%0h)",
                         tn[i], got_rx, got_ry, ex[i], ey[i]);
            end
            vectors++;
            if (lat != LAT) begin
                miscompares++;
                $display("FAIL extremes_latency n=%0h: got %0d required %0d", tn[i], lat, LAT);
            end
        end
        last_x = 8'hFF;
        last_y = 8'hFE;
    endtask

    // Random scalars; also checks the operand buses and that results hold while busy.
    task automatic test_random_bus();
        logic [W-1:0] nv, qx, qy, ex_px, ex_py, ex_qx, ex_qy;
        int unsigned pre;
        int bus_bad;
        for (int i = 0; i < 20; i++) begin
            nv = (i == 0) ? 8'd1 : (i == 1) ? 8'd2 : W'($urandom);
            qx = W'($urandom);
            qy = W'($urandom);
            do_op(nv, qx, qy);
            vectors++;
            if (got_rx !== smul(nv, qx) || got_ry !== smul(nv, qy)) begin
                miscompares++;
                $display("FAIL random_result n=%0h Q=(%0h,%0h): got (%0h,%0h) required (%0h,%0h)",
                         nv, qx, qy, got_rx, got_ry, smul(nv, qx), smul(nv, qy));
            end
            vectors++;
            if (lat != LAT || busy_cnt != 2 * W) begin
                miscompares++;
                $display("FAIL random_timing n=%0h: latency %0d busy %0d required %0d and %0d",
                         nv, lat, busy_cnt, LAT, 2 * W);
            end
            if (lat == LAT) begin
                bus_bad = 0;
                for (int c = 0; c <= 2 * W; c++) begin
                    pre = int'(nv) >> (W - c / 2);
                    if (c == 2 * W) begin
                        {ex_px, ex_py, ex_qx, ex_qy} = '0;
                    end else if (c % 2 == 0) begin
                        ex_px = smul(pre, qx);
                        ex_py = smul(pre, qy);
                        ex_qx = ex_px;
                        ex_qy = ex_py;
                    end else begin
                        ex_px = smul(2 * pre, qx);
                        ex_py = smul(2 * pre, qy);
                        ex_qx = qx;
                        ex_qy = qy;
                    end
                    vectors++;
                    if ({obs_px[c], obs_py[c], obs_qx[c], obs_qy[c]} !==
                        {ex_px, ex_py, ex_qx, ex_qy}) begin
                        miscompares++;
                        bus_bad++;
                        if (bus_bad < 3)
                            $display("FAIL operand_bus n=%0h cyc=%0d: got %0h %0h %0h %0h required %0h %0h %0h %0h",
                                     nv, c, obs_px[c], obs_py[c], obs_qx[c], obs_qy[c],
                                     ex_px, ex_py, ex_qx, ex_qy);
                    end
                end
                vectors++;
                for (int c = 0; c < 2 * W; c++) begin
                    if (obs_rx[c] !== last_x || obs_ry[c] !== last_y) begin
                        miscompares++;
                        $display("FAIL result_hold cyc=%0d: got (%0h,%0h) required (%0h,%0h)",
                                 c, obs_rx[c], obs_ry[c], last_x, last_y);
                        break;
                    end
                end
            end
            last_x = smul(nv, qx);
            last_y = smul(nv, qy);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] on [3];
        logic [W-1:0] ox [3];
        logic [W-1:0] oy [3];
        int done_t [3];
        int cur, t, guard;
        for (int i = 0; i < 3; i++) begin
            on[i] = W'($urandom_range(1, 255));
            ox[i] = W'($urandom);
            oy[i] = W'($urandom);
        end
        guard = 0;
        @(negedge clk);
        while ((busy || done) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        start = 1'b1;
        n = on[0];
        Qx = ox[0];
        Qy = oy[0];
        cur = 0;
        t = 0;
        while (cur < 3 && t < 200) begin
            @(posedge clk);
            t++;
            @(negedge clk);
            if (done) begin
                done_t[cur] = t;
                vectors++;
                if (Rx_out !== smul(on[cur], ox[cur]) || Ry_out !== smul(on[cur], oy[cur])) begin
                    miscompares++;
                    $display("FAIL b2b_result op%0d: got (%0h,%0h) required (%0h,%0h)", cur,
                             Rx_out, Ry_out, smul(on[cur], ox[cur]), smul(on[cur], oy[cur]));
                end
                cur++;
                if (cur < 3) begin
                    n = on[cur];
                    Qx = ox[cur];
                    Qy = oy[cur];
                end else begin
                    start = 1'b0;
                end
            end else if (busy) begin
                n = W'($urandom);
                Qx = W'($urandom);
                Qy = W'($urandom);
            end
        end
        start = 1'b0;
        vectors++;
        if (cur < 3) begin
            miscompares++;
            $display("FAIL b2b_timeout: got %0d results required 3", cur);
        end else if (done_t[0] != LAT || done_t[1] - done_t[0] != LAT + 1 ||
                     done_t[2] - done_t[1] != LAT + 1) begin
            miscompares++;
            $display("FAIL b2b_spacing: done at %0d %0d %0d required %0d %0d %0d", done_t[0],
                     done_t[1], done_t[2], LAT, 2 * LAT + 1, 3 * LAT + 2);
        end
        last_x = smul(on[2], ox[2]);
        last_y = smul(on[2], oy[2]);
    endtask

    task automatic test_reset_mid();
        int done_seen;
        @(negedge clk);
        start = 1'b1;
        n = 8'hB5;
        Qx = 8'd3;
        Qy = 8'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, Rx_out, Ry_out} !== {2'b00, 16'h0}) begin
            miscompares++;
            $display("FAIL midreset_outputs: busy=%0b done=%0b R=(%0h,%0h) required 0,0,(0,0)",
                     busy, done, Rx_out, Ry_out);
        end
        vectors++;
        if ({add_Px, add_Py, add_Qx, add_Qy} !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_operands: got %0h %0h %0h %0h required all 0",
                     add_Px, add_Py, add_Qx, add_Qy);
        end
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        vectors++;
        if (done_seen != 0) begin
            miscompares++;
            $display("FAIL midreset_no_done: got %0d active cycles required 0", done_seen);
        end
        do_op(8'd3, 8'd5, 8'd5);
        vectors++;
        if ({got_rx, got_ry} !== {8'd15, 8'd15} || lat != LAT) begin
            miscompares++;
            $display("FAIL midreset_restart: got (%0d,%0d) latency %0d required (15,15) latency %0d",
                     got_rx, got_ry, lat, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_stub_arith();
        test_scalar_extremes();
        test_random_bus();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
